// File: rtl/pipe_adder_pkg.sv
// Shared configuration for the pipelined ripple add/subtract unit.
// Build with PIPE_ADDER_OVERFLOW_EN defined to add the signed-overflow output.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    // Width-independent part of every stage record; the partial sum and the
    // pending operand slices are sized per stage in the top module.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_flags_t;

    function automatic int stages(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/pipelined_ripple_adder_adder_slice.sv
// Combinational SLICE-bit ripple-carry adder: one full adder per bit,
// carry in at bit 0 and carry out of the top bit.
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: one SLICE-bit ripple per stage, carry registered
// between stages. Optional signed overflow output under PIPE_ADDER_OVERFLOW_EN.
module pipelined_ripple_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PIPE_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STAGES = stages(WIDTH, SLICE);

    // Handshake: a transfer occurs on each side in any cycle where valid and
    // ready are both high; valid never waits on ready. The whole pipeline
    // moves as one shift register, so input ready is simply "output slot free".
    logic             advance;
    logic [WIDTH-1:0] b_eff;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * SLICE;
        localparam int DONE = (k + 1) * SLICE;

        logic [REM-1:0]   op_a;
        logic [REM-1:0]   op_b;
        logic             cin;
        logic             v_in;
        logic [SLICE-1:0] slice_sum;
        logic             cout;
        logic [DONE-1:0]  psum_d;
        logic [DONE-1:0]  psum_q;
        stage_flags_t     flags_q;

        if (k == 0) begin : g_entry
            assign op_a   = a;
            assign op_b   = b_eff;
            assign cin    = sub;
            assign v_in   = in_valid & in_ready;
            assign psum_d = slice_sum;
        end else begin : g_inner
            // Operand slices not yet consumed ride along with the previous
            // stage's partial sum so both reach this adder together.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    op_a <= '0;
                    op_b <= '0;
                end else if (advance) begin
                    op_a <= g_stage[k-1].op_a[REM+SLICE-1:SLICE];
                    op_b <= g_stage[k-1].op_b[REM+SLICE-1:SLICE];
                end
            end
            assign cin    = g_stage[k-1].flags_q.carry;
            assign v_in   = g_stage[k-1].flags_q.valid;
            assign psum_d = {slice_sum, g_stage[k-1].psum_q};
        end

        adder_slice #(.SLICE(SLICE)) u_slice (
            .a    (op_a[SLICE-1:0]),
            .b    (op_b[SLICE-1:0]),
            .cin  (cin),
            .sum  (slice_sum),
            .cout (cout)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                flags_q <= '0;
                psum_q  <= '0;
            end else if (advance) begin
                flags_q <= '{valid: v_in, carry: cout};
                psum_q  <= psum_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].flags_q.valid;
    assign carry_out = g_stage[STAGES-1].flags_q.carry;
    assign sum       = g_stage[STAGES-1].psum_q;

`ifdef PIPE_ADDER_OVERFLOW_EN
    // The operand MSBs are still pending at the last adder, so overflow is
    // decided there and registered alongside the final slice.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (g_stage[STAGES-1].op_a[SLICE-1] == g_stage[STAGES-1].op_b[SLICE-1])
                 & (g_stage[STAGES-1].slice_sum[SLICE-1] != g_stage[STAGES-1].op_a[SLICE-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed self-checking bench for pipelined_ripple_adder (WIDTH=16, SLICE=4).
// Overflow checks are compiled in when PIPE_ADDER_OVERFLOW_EN is defined.
module tb_pipelined_ripple_adder;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef PIPE_ADDER_OVERFLOW_EN
    logic             overflow;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] exp_q[$];

    // Directed stream vectors; expected value is {carry_out, sum}.
    logic [WIDTH-1:0] vec_a   [8] = '{16'h1234, 16'h8000, 16'h0F0F, 16'hABCD,
                                      16'h0000, 16'hFFF0, 16'h7FFF, 16'h1000};
    logic [WIDTH-1:0] vec_b   [8] = '{16'h4321, 16'h8000, 16'h00F1, 16'h1111,
                                      16'h0001, 16'h0010, 16'h7FFF, 16'h1000};
    logic             vec_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [WIDTH:0]   vec_exp [8] = '{17'h0_5555, 17'h1_0000, 17'h0_1000, 17'h1_9ABC,
                                      17'h0_FFFF, 17'h1_0000, 17'h0_FFFE, 17'h1_0000};

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef PIPE_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
    endtask

    // One isolated operation; reports the result and the cycle count from the
    // accepting edge (counted as 1) to out_valid.
    task automatic run_single(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input logic sv, output logic [WIDTH-1:0] s,
                              output logic c, output logic ov, output int lat);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        sub       = sv;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        s = sum;
        c = carry_out;
`ifdef PIPE_ADDER_OVERFLOW_EN
        ov = overflow;
`else
        ov = 1'b0;
`endif
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
`ifdef PIPE_ADDER_OVERFLOW_EN
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] s;
        logic c, ov;
        int lat;
        run_single(16'h00F5, 16'h0003, 1'b0, s, c, ov, lat);
        checks++; if (lat !== STAGES) begin failures++; $display("FAIL add_small_latency: got %0d expected %0d", lat, STAGES); end
        checks++; if (s !== 16'h00F8) begin failures++; $display("FAIL add_small_sum: got %h expected 00f8", s); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL add_small_carry: got %b expected 0", c); end
        run_single(16'hFFFF, 16'h0001, 1'b0, s, c, ov, lat);
        checks++; if (lat !== STAGES) begin failures++; $display("FAIL add_wrap_latency: got %0d expected %0d", lat, STAGES); end
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL add_wrap_sum: got %h expected 0000", s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL add_wrap_carry: got %b expected 1", c); end
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] s;
        logic c, ov;
        int lat;
        run_single(16'h0005, 16'h0007, 1'b1, s, c, ov, lat);
        checks++; if (lat !== STAGES) begin failures++; $display("FAIL sub_borrow_latency: got %0d expected %0d", lat, STAGES); end
        checks++; if (s !== 16'hFFFE) begin failures++; $display("FAIL sub_borrow_sum: got %h expected fffe", s); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL sub_borrow_carry: got %b expected 0", c); end
        run_single(16'h0007, 16'h0005, 1'b1, s, c, ov, lat);
        checks++; if (s !== 16'h0002) begin failures++; $display("FAIL sub_pos_sum: got %h expected 0002", s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL sub_pos_carry: got %b expected 1", c); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int got = 0;
        int first_cyc = 0;
        int last_cyc = 0;
        logic [WIDTH:0] exp;
        exp_q.delete();
        drive_idle();
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b2b_extra_result: got %h expected no result", {carry_out, sum});
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if ({carry_out, sum} !== exp) begin
                        failures++;
                        $display("FAIL b2b_result_%0d: got %h expected %h", got, {carry_out, sum}, exp);
                    end
                end
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (idx < 8) begin
                a = vec_a[idx]; b = vec_b[idx]; sub = vec_sub[idx]; in_valid = 1'b1;
                exp_q.push_back(vec_exp[idx]);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got !== 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", got); end
        checks++; if (last_cyc - first_cyc !== 7) begin failures++; $display("FAIL b2b_consecutive: got span %0d expected 7", last_cyc - first_cyc); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_leftover: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int hold = 0;
        int held_cycles = 0;
        logic seen_first = 1'b0;
        logic [WIDTH:0] exp;
        exp_q.delete();
        drive_idle();
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (out_valid && !seen_first) begin
                seen_first = 1'b1;
                hold = 3;
            end
            out_ready = (hold == 0);
            #1;
            if (hold > 0) begin
                held_cycles++;
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_hold: got %b expected 0", in_ready); end
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold: got %b expected 1", out_valid); end
                checks++; if ({carry_out, sum} !== exp_q[0]) begin failures++; $display("FAIL bp_stable_hold: got %h expected %h", {carry_out, sum}, exp_q[0]); end
                hold--;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bp_extra_result: got %h expected no result", {carry_out, sum});
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if ({carry_out, sum} !== exp) begin
                        failures++;
                        $display("FAIL bp_result_%0d: got %h expected %h", got, {carry_out, sum}, exp);
                    end
                end
                got++;
            end
            if (sent < 6) begin
                a = vec_a[sent]; b = vec_b[sent]; sub = vec_sub[sent]; in_valid = 1'b1;
                if (in_ready) begin
                    exp_q.push_back(vec_exp[sent]);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        drive_idle();
        checks++; if (got !== 6) begin failures++; $display("FAIL bp_count: got %0d expected 6", got); end
        checks++; if (held_cycles !== 3) begin failures++; $display("FAIL bp_hold_cycles: got %0d expected 3", held_cycles); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_leftover: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_flush();
        int emerged = 0;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            a = vec_a[i]; b = vec_b[i]; sub = vec_sub[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) emerged++;
        end
        checks++; if (emerged !== 0) begin failures++; $display("FAIL flush_emerged: got %0d results expected 0", emerged); end
    endtask

`ifdef PIPE_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [WIDTH-1:0] s;
        logic c, ov;
        int lat;
        run_single(16'h7FFF, 16'h0001, 1'b0, s, c, ov, lat);
        checks++; if (s !== 16'h8000) begin failures++; $display("FAIL ovf_add_sum: got %h expected 8000", s); end
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_add_flag: got %b expected 1", ov); end
        run_single(16'h8000, 16'h0001, 1'b1, s, c, ov, lat);
        checks++; if (s !== 16'h7FFF) begin failures++; $display("FAIL ovf_sub_sum: got %h expected 7fff", s); end
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_sub_flag: got %b expected 1", ov); end
        run_single(16'h0005, 16'h0007, 1'b1, s, c, ov, lat);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL ovf_none_flag: got %b expected 0", ov); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "simulation time limit");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
`ifdef PIPE_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
